// File: rtl/lead_norm_pkg.sv
// Shared constants, opcode encodings and FSM state type for the
// lead-count / normalize custom instruction.
package lead_norm_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    localparam logic [1:0] OP_CLO   = 2'd0;
    localparam logic [1:0] OP_CLZ   = 2'd1;
    localparam logic [1:0] OP_NORM  = 2'd2;
    localparam logic [1:0] OP_GETSH = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] zext_cnt(input logic [CNT_W-1:0] c);
        return {{(DATA_W-CNT_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/lead_norm_ci_if.sv
// Nios II multi-cycle custom-instruction port bundle (CPU = master, CI = slave).
interface lead_norm_ci_if;
    import lead_norm_pkg::*;

    // Handshake: the master pulses start for one clk_en cycle with n/dataa
    // valid; the slave later pulses done for one clk_en cycle with result
    // valid. Starts seen while the slave is busy are dropped.
    logic              start;
    logic [1:0]        n;
    logic [DATA_W-1:0] dataa;
    logic [DATA_W-1:0] datab;
    logic              done;
    logic [DATA_W-1:0] result;

    modport master (output start, n, dataa, datab, input done, result);
    modport slave  (input start, n, dataa, datab, output done, result);

endinterface

// File: rtl/lead_scan_dp.sv
// Scan datapath: shift register, run counter and stop compare. The compare
// looks at the operand being loaded, so the start cycle is the first scan step.
module lead_scan_dp
    import lead_norm_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic              target,
    input  logic [DATA_W-1:0] data,
    output logic              stop,
    output logic [DATA_W-1:0] shreg,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] cur;
    logic [CNT_W-1:0]  cur_cnt;

    assign cur     = load ? data : shreg;
    assign cur_cnt = load ? '0 : cnt;
    assign stop    = (cur_cnt == CNT_W'(DATA_W)) || (cur[DATA_W-1] != target);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load || step) begin
            if (stop) begin
                shreg <= cur;
                cnt   <= cur_cnt;
            end else begin
                shreg <= cur << 1;
                cnt   <= cur_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lead_norm_ci.sv
// Count-leading-ones/zeros and normalize custom instruction: FSM, opcode
// latch and registered done/result/last_shift around the scan datapath.
module lead_norm_ci
    import lead_norm_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_en,
    lead_norm_ci_if.slave  ci,
    output state_t         state_dbg
);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        op;
    logic              target;
    logic [CNT_W-1:0]  last_shift;
    logic              done_q;
    logic [DATA_W-1:0] result_q;

    logic              accept;
    logic              scan_op;
    logic              load;
    logic              step;
    logic              tgt_sel;
    logic              stop;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              unused_datab;

    assign unused_datab = ^ci.datab;

    lead_scan_dp u_scan (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (step),
        .target (tgt_sel),
        .data   (ci.dataa),
        .stop   (stop),
        .shreg  (shreg),
        .cnt    (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (scan_op && !stop) ? SCAN : FIN;
            SCAN: if (stop) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the target bit comes straight from the opcode being issued.
    always_comb begin
        accept  = (state == IDLE) && ci.start && clk_en;
        scan_op = (ci.n != OP_GETSH);
        load    = accept && scan_op;
        step    = (state == SCAN) && clk_en;
        tgt_sel = (state == IDLE) ? (ci.n == OP_CLO) : target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q     <= 1'b0;
            result_q   <= '0;
            last_shift <= '0;
            op         <= OP_CLO;
            target     <= 1'b0;
        end else if (clk_en) begin
            done_q <= (state == FIN);
            if (accept) begin
                op     <= ci.n;
                target <= (ci.n == OP_CLO);
            end
            if (state == FIN) begin
                case (op)
                    OP_CLO, OP_CLZ: result_q <= zext_cnt(cnt);
                    OP_NORM: begin
                        result_q   <= shreg;
                        last_shift <= cnt;
                    end
                    default: result_q <= zext_cnt(last_shift);
                endcase
            end
        end
    end

    assign ci.done   = done_q;
    assign ci.result = result_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lead_norm_ci.sv
// Directed scoreboard bench for lead_norm_ci: driver pushes expected result
// and done cycle, a negedge monitor pops on each done pulse.
module tb_lead_norm_ci;
    import lead_norm_pkg::*;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   clk_en = 1'b1;
    state_t state_dbg;

    lead_norm_ci_if ci();

    lead_norm_ci dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .ci        (ci),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        int          c;
        if (ci.done === 1'b1 && !prev_done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got result 0x%08h, required no done (cycle %0d)", ci.result, cyc);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("result", ci.result, e);
                check("done_cycle", cyc, c);
            end
        end
        prev_done = (ci.done === 1'b1);
    end

    // driver tasks
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input bit push,
                         input logic [31:0] er, input int lat);
        @(negedge clk);
        ci.start = 1'b1;
        ci.n     = op;
        ci.dataa = a;
        ci.datab = $urandom;
        if (push) begin
            exp_q.push_back(er);
            exp_cyc_q.push_back(cyc + lat);
        end
        @(negedge clk);
        ci.start = 1'b0;
        ci.n     = 2'($urandom_range(0, 3));
        ci.dataa = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int t;
        ci.start = 1'b0;
        ci.n     = 2'd0;
        ci.dataa = '0;
        ci.datab = '0;
        repeat (3) @(negedge clk);
        check("reset_done", 32'(ci.done), 32'd0);
        check("reset_result", ci.result, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;

        issue(OP_CLO, 32'hFFFF_0000, 1, 32'd16, 18);
        wait_idle("clo_16");
        issue(OP_CLZ, 32'h0000_0000, 1, 32'd32, 34);
        wait_idle("clz_zero");
        issue(OP_CLO, 32'h7FFF_FFFF, 1, 32'd0, 2);
        wait_idle("clo_zero");
        issue(OP_NORM, 32'h00F0_1234, 1, 32'hF012_3400, 10);
        wait_idle("norm_8");
        issue(OP_GETSH, 32'h0, 1, 32'd8, 2);
        wait_idle("getsh_8");
        issue(OP_CLO, 32'h1234_5678, 1, 32'd0, 2);
        wait_idle("clo_other");
        issue(OP_GETSH, 32'h0, 1, 32'd8, 2);
        wait_idle("getsh_kept");
        issue(OP_NORM, 32'h8000_0001, 1, 32'h8000_0001, 2);
        issue(OP_GETSH, 32'h0, 1, 32'd0, 2);
        wait_idle("norm_msb");
        issue(OP_NORM, 32'h0, 1, 32'h0, 34);
        wait_idle("norm_zero");
        issue(OP_GETSH, 32'h0, 1, 32'd32, 2);
        wait_idle("getsh_32");
        issue(OP_CLZ, 32'h0000_FFFF, 1, 32'd16, 18);
        wait_idle("clz_16");

        // clk_en dropped for 5 cycles mid-scan
        issue(OP_CLO, 32'hF000_0000, 1, 32'd4, 11);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        wait_idle("stall");

        // done held while clk_en is low
        issue(OP_GETSH, 32'h0, 1, 32'd32, 2);
        t = 0;
        while (ci.done !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        clk_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("done_hold", 32'(ci.done), 32'd1);
        end
        clk_en = 1'b1;
        @(negedge clk);
        check("done_clear", 32'(ci.done), 32'd0);
        wait_idle("done_hold");

        // start while busy is dropped
        issue(OP_CLO, 32'hFF00_0000, 1, 32'd8, 10);
        @(negedge clk);
        issue(OP_CLZ, 32'h0, 0, 32'd0, 0);
        wait_idle("busy");
        repeat (40) @(negedge clk);

        // reset mid-scan aborts
        issue(OP_NORM, 32'h0000_0001, 0, 32'd0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", ci.result, 32'd0);
        check("abort_state", 32'(state_dbg), 32'(IDLE));
        repeat (40) @(negedge clk);
        check("abort_done", 32'(ci.done), 32'd0);
        issue(OP_GETSH, 32'h0, 1, 32'd0, 2);
        wait_idle("getsh_after_reset");
        issue(OP_CLO, 32'hFFFF_FFFF, 1, 32'd32, 34);
        wait_idle("clo_all_ones");

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
